// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I(+M) control FSM: FETCH/DECODE/EXEC/MEM/MULDIV/WB/TRAP.
// Datapath controls come from IR fields latched in DECODE. Strobes depend on the current state.
module multicycle_control_unit #(
   parameter int ENABLE_M  = 0,
   parameter int MD_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       mem_ready,
   input  logic       br_taken,
   output logic       ru_write,
   output logic [3:0] alu_op,
   output logic [2:0] imm_src,
   output logic [1:0] alu_a_src,
   output logic       alu_b_src,
   output logic       dm_write,
   output logic [2:0] dm_ctrl,
   output logic [4:0] br_op,
   output logic [1:0] ru_data_src,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       ir_write,
   output logic       mem_req,
   output logic       md_start,
   output logic [2:0] md_op,
   output logic       busy,
   output logic       illegal
);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] F7_MULDIV = 7'b0000001;
   localparam int            CW      = $clog2(MD_CYCLES) + 1;
   localparam logic [CW-1:0] MD_LAST = CW'(MD_CYCLES - 1);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MULDIV, S_WB, S_TRAP
   } state_t;

   state_t        state, state_nx;
   logic [6:0]    op_q, f7_q;
   logic [2:0]    f3_q;
   logic [CW-1:0] cnt;
   logic          legal_in, is_m, is_st;

   assign is_m  = (ENABLE_M != 0) && (op_q == OP_R) && (f7_q == F7_MULDIV);
   assign is_st = (op_q == OP_ST);

   // Legality is judged on the live fields, which are only meaningful in DECODE.
   always_comb begin
      legal_in = 1'b0;
      case (opcode)
         OP_R:   legal_in = (funct7 != F7_MULDIV) || (ENABLE_M != 0);
         OP_I, OP_LD, OP_ST, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                 legal_in = 1'b1;
         default: legal_in = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         op_q  <= '0;
         f3_q  <= '0;
         f7_q  <= '0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state == S_DECODE) begin
            op_q <= opcode;
            f3_q <= funct3;
            f7_q <= funct7;
         end
         cnt <= (state == S_MULDIV) ? cnt + 1'b1 : '0;
      end
   end

   // Datapath selects: only driven in EXEC..WB, from the latched fields.
   always_comb begin
      alu_op      = '0;
      imm_src     = '0;
      alu_a_src   = '0;
      alu_b_src   = 1'b0;
      dm_ctrl     = '0;
      br_op       = '0;
      ru_data_src = '0;
      md_op       = '0;
      if (!rst && (state inside {S_EXEC, S_MEM, S_MULDIV, S_WB})) begin
         case (op_q)
            OP_R: begin
               alu_op = {f7_q[5], f3_q};
               if (is_m) begin
                  ru_data_src = 2'b11;
                  md_op       = f3_q;
               end
            end
            OP_I: begin
               alu_op    = {(f3_q == 3'b101) ? f7_q[5] : 1'b0, f3_q};
               alu_b_src = 1'b1;
            end
            OP_LD: begin
               alu_b_src   = 1'b1;
               dm_ctrl     = f3_q;
               ru_data_src = 2'b01;
            end
            OP_ST: begin
               imm_src   = 3'b001;
               alu_b_src = 1'b1;
               dm_ctrl   = f3_q;
            end
            OP_BR: begin
               imm_src = 3'b010;
               br_op   = {2'b01, f3_q};
            end
            OP_JAL: begin
               imm_src     = 3'b100;
               br_op       = 5'b10000;
               ru_data_src = 2'b10;
            end
            OP_JALR: begin
               br_op       = 5'b10000;
               ru_data_src = 2'b10;
            end
            OP_LUI: begin
               alu_a_src = 2'b10;
               imm_src   = 3'b011;
               alu_b_src = 1'b1;
            end
            OP_AUIPC: begin
               alu_a_src = 2'b01;
               imm_src   = 3'b011;
               alu_b_src = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      ru_write = 1'b0;
      dm_write = 1'b0;
      pc_write = 1'b0;
      pc_src   = 2'b00;
      ir_write = 1'b0;
      mem_req  = 1'b0;
      md_start = 1'b0;
      busy     = 1'b0;
      illegal  = 1'b0;
      case (state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               state_nx = S_DECODE;
            end
         end
         S_DECODE: begin
            busy     = 1'b1;
            state_nx = legal_in ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            busy = 1'b1;
            case (op_q)
               OP_LD, OP_ST: state_nx = S_MEM;
               OP_BR: begin
                  pc_write = 1'b1;
                  pc_src   = br_taken ? 2'b01 : 2'b00;
                  state_nx = S_FETCH;
               end
               OP_R:    state_nx = is_m ? S_MULDIV : S_WB;
               default: state_nx = S_WB;
            endcase
         end
         S_MEM: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            dm_write = is_st;
            if (mem_ready) begin
               pc_write = is_st;
               state_nx = is_st ? S_FETCH : S_WB;
            end
         end
         S_MULDIV: begin
            busy     = 1'b1;
            md_start = (cnt == '0);
            if (cnt == MD_LAST) state_nx = S_WB;
         end
         S_WB: begin
            busy     = 1'b1;
            ru_write = 1'b1;
            pc_write = 1'b1;
            if (op_q == OP_JAL)       pc_src = 2'b01;
            else if (op_q == OP_JALR) pc_src = 2'b10;
            state_nx = S_FETCH;
         end
         S_TRAP: begin
            busy    = 1'b1;
            illegal = 1'b1;
         end
         default: state_nx = S_FETCH;
      endcase
      // Outputs are forced quiet while reset is held.
      if (rst) begin
         ru_write = 1'b0;
         dm_write = 1'b0;
         pc_write = 1'b0;
         pc_src   = 2'b00;
         ir_write = 1'b0;
         mem_req  = 1'b0;
         md_start = 1'b0;
         busy     = 1'b0;
         illegal  = 1'b0;
      end
   end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: a table of instructions walked through every FSM state,
// plus hand-written reset-abort and ENABLE_M=0 trap sequences.
module tb_multicycle_control_unit;
   localparam int MDC = 4;
   localparam logic [2:0] K_ALU = 3'd0, K_LD = 3'd1, K_ST = 3'd2, K_BR = 3'd3,
                          K_JMP = 3'd4, K_MD = 3'd5, K_ILL = 3'd6;

   typedef struct packed {
      logic       ru_write;
      logic [3:0] alu_op;
      logic [2:0] imm_src;
      logic [1:0] alu_a_src;
      logic       alu_b_src;
      logic       dm_write;
      logic [2:0] dm_ctrl;
      logic [4:0] br_op;
      logic [1:0] ru_data_src;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       ir_write;
      logic       mem_req;
      logic       md_start;
      logic [2:0] md_op;
      logic       busy;
      logic       illegal;
   } out_t;

   typedef struct packed {
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       br;
      logic [2:0] kind;
      logic [1:0] mw;
      logic [3:0] alu_op;
      logic [2:0] imm;
      logic [1:0] a;
      logic       b;
      logic [2:0] dm;
      logic [4:0] brop;
      logic [1:0] ds;
      logic [1:0] pcs;
   } vec_t;

   logic clk = 1'b0, rst = 1'b1;
   logic [6:0] opcode = '0, funct7 = '0;
   logic [2:0] funct3 = '0;
   logic mem_ready = 1'b0, br_taken = 1'b0;

   logic ru_write, alu_b_src, dm_write, pc_write, ir_write, mem_req, md_start, busy, illegal;
   logic [3:0] alu_op;
   logic [2:0] imm_src, dm_ctrl, md_op;
   logic [1:0] alu_a_src, ru_data_src, pc_src;
   logic [4:0] br_op;

   logic d0_ru_write, d0_alu_b_src, d0_dm_write, d0_pc_write, d0_ir_write, d0_mem_req;
   logic d0_md_start, d0_busy, d0_illegal;
   logic [3:0] d0_alu_op;
   logic [2:0] d0_imm_src, d0_dm_ctrl, d0_md_op;
   logic [1:0] d0_alu_a_src, d0_ru_data_src, d0_pc_src;
   logic [4:0] d0_br_op;

   always #5 clk = ~clk;

   multicycle_control_unit #(.ENABLE_M(1), .MD_CYCLES(MDC)) u_dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .br_taken(br_taken),
      .ru_write(ru_write), .alu_op(alu_op), .imm_src(imm_src), .alu_a_src(alu_a_src),
      .alu_b_src(alu_b_src), .dm_write(dm_write), .dm_ctrl(dm_ctrl), .br_op(br_op),
      .ru_data_src(ru_data_src), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
      .mem_req(mem_req), .md_start(md_start), .md_op(md_op), .busy(busy), .illegal(illegal)
   );

   // Default-parameter copy sharing all stimulus; only watched around the M-op case.
   multicycle_control_unit u_dut0 (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .mem_ready(mem_ready), .br_taken(br_taken),
      .ru_write(d0_ru_write), .alu_op(d0_alu_op), .imm_src(d0_imm_src), .alu_a_src(d0_alu_a_src),
      .alu_b_src(d0_alu_b_src), .dm_write(d0_dm_write), .dm_ctrl(d0_dm_ctrl), .br_op(d0_br_op),
      .ru_data_src(d0_ru_data_src), .pc_write(d0_pc_write), .pc_src(d0_pc_src),
      .ir_write(d0_ir_write), .mem_req(d0_mem_req), .md_start(d0_md_start), .md_op(d0_md_op),
      .busy(d0_busy), .illegal(d0_illegal)
   );

   out_t act, act0, exp0;
   assign act = {ru_write, alu_op, imm_src, alu_a_src, alu_b_src, dm_write, dm_ctrl, br_op,
                 ru_data_src, pc_write, pc_src, ir_write, mem_req, md_start, md_op, busy, illegal};
   assign act0 = {d0_ru_write, d0_alu_op, d0_imm_src, d0_alu_a_src, d0_alu_b_src, d0_dm_write,
                  d0_dm_ctrl, d0_br_op, d0_ru_data_src, d0_pc_write, d0_pc_src, d0_ir_write,
                  d0_mem_req, d0_md_start, d0_md_op, d0_busy, d0_illegal};

   out_t sb[$];
   int checks = 0, failures = 0;
   logic chk0 = 1'b0;
   vec_t vecs[13];
   vec_t v_mul;

   function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [6:0] f7, logic br,
                               logic [2:0] kind, logic [1:0] mw, logic [3:0] aop, logic [2:0] imm,
                               logic [1:0] a, logic b, logic [2:0] dm, logic [4:0] brop,
                               logic [1:0] ds, logic [1:0] pcs);
      vec_t v;
      v = {op, f3, f7, br, kind, mw, aop, imm, a, b, dm, brop, ds, pcs};
      return v;
   endfunction

   function automatic out_t fields(vec_t v);
      out_t e;
      e             = '0;
      e.busy        = 1'b1;
      e.alu_op      = v.alu_op;
      e.imm_src     = v.imm;
      e.alu_a_src   = v.a;
      e.alu_b_src   = v.b;
      e.dm_ctrl     = v.dm;
      e.br_op       = v.brop;
      e.ru_data_src = v.ds;
      e.md_op       = (v.kind == K_MD) ? v.f3 : 3'b000;
      return e;
   endfunction

   // Called at a negedge with inputs already driven; compares, then advances one cycle.
   task automatic step(input string nm, input out_t e);
      out_t x;
      sb.push_back(e);
      #2;
      x = sb.pop_front();
      checks++;
      if (act !== x) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, x);
      end
      if (chk0) begin
         checks++;
         if (act0 !== exp0) begin
            failures++;
            $display("FAIL %s_m_off: got %h expected %h", nm, act0, exp0);
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mem_ready = 1'b0;
      step("reset", '0);
      rst = 1'b0;
   endtask

   task automatic abort_reset();
      out_t e;
      rst = 1'b1;
      mem_ready = 1'b0;
      step("rst_mid_op", '0);
      rst = 1'b0;
      e = '0;
      e.mem_req = 1'b1;
      step("fetch_after_rst", e);
   endtask

   task automatic run(input vec_t v, input bit abort);
      out_t e;
      opcode = v.op; funct3 = v.f3; funct7 = v.f7;
      mem_ready = 1'b1; br_taken = 1'b0;
      e = '0; e.mem_req = 1'b1; e.ir_write = 1'b1;
      step("fetch", e);
      mem_ready = 1'b0;
      e = '0; e.busy = 1'b1;
      step("decode", e);
      opcode = 7'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
      if (v.kind == K_ILL) begin
         for (int i = 0; i < 3; i++) begin
            e = '0; e.busy = 1'b1; e.illegal = 1'b1;
            step("trap", e);
         end
         do_reset();
         return;
      end
      br_taken = v.br;
      e = fields(v);
      if (v.kind == K_BR) begin
         e.pc_write = 1'b1;
         e.pc_src   = v.pcs;
      end
      step("exec", e);
      br_taken = 1'b0;
      if (v.kind == K_BR) return;
      if (v.kind == K_LD || v.kind == K_ST) begin
         for (int i = 0; i < int'(v.mw); i++) begin
            e = fields(v); e.mem_req = 1'b1; e.dm_write = (v.kind == K_ST);
            step("mem_wait", e);
            if (abort) begin
               abort_reset();
               return;
            end
         end
         mem_ready = 1'b1;
         e = fields(v); e.mem_req = 1'b1; e.dm_write = (v.kind == K_ST);
         e.pc_write = (v.kind == K_ST);
         step("mem_done", e);
         mem_ready = 1'b0;
         if (v.kind == K_ST) return;
      end
      if (v.kind == K_MD) begin
         for (int i = 0; i < MDC; i++) begin
            e = fields(v); e.md_start = (i == 0);
            step("muldiv", e);
            if (abort && i == 1) begin
               abort_reset();
               return;
            end
         end
      end
      e = fields(v); e.ru_write = 1'b1; e.pc_write = 1'b1;
      e.pc_src = (v.kind == K_JMP) ? v.pcs : 2'b00;
      step("wb", e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      out_t e;
      //            op          f3      f7          br  kind   mw  aop      imm     a      b    dm      brop        ds     pcs
      vecs[0]  = mk(7'b0110011, 3'b000, 7'b0000000, 1, K_ALU, 0, 4'b0000, 3'b000, 2'b00, 0, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[1]  = mk(7'b0110011, 3'b000, 7'b0100000, 0, K_ALU, 0, 4'b1000, 3'b000, 2'b00, 0, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[2]  = mk(7'b0010011, 3'b101, 7'b0100000, 0, K_ALU, 0, 4'b1101, 3'b000, 2'b00, 1, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[3]  = mk(7'b0010011, 3'b000, 7'b0100000, 0, K_ALU, 0, 4'b0000, 3'b000, 2'b00, 1, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[4]  = mk(7'b0000011, 3'b010, 7'b0000000, 0, K_LD,  3, 4'b0000, 3'b000, 2'b00, 1, 3'b010, 5'b00000, 2'b01, 2'b00);
      vecs[5]  = mk(7'b0100011, 3'b000, 7'b0000000, 0, K_ST,  1, 4'b0000, 3'b001, 2'b00, 1, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[6]  = mk(7'b1100011, 3'b000, 7'b0000000, 1, K_BR,  0, 4'b0000, 3'b010, 2'b00, 0, 3'b000, 5'b01000, 2'b00, 2'b01);
      vecs[7]  = mk(7'b1100011, 3'b001, 7'b0000000, 0, K_BR,  0, 4'b0000, 3'b010, 2'b00, 0, 3'b000, 5'b01001, 2'b00, 2'b00);
      vecs[8]  = mk(7'b1101111, 3'b000, 7'b0000000, 0, K_JMP, 0, 4'b0000, 3'b100, 2'b00, 0, 3'b000, 5'b10000, 2'b10, 2'b01);
      vecs[9]  = mk(7'b1100111, 3'b000, 7'b0000000, 0, K_JMP, 0, 4'b0000, 3'b000, 2'b00, 0, 3'b000, 5'b10000, 2'b10, 2'b10);
      vecs[10] = mk(7'b0110111, 3'b000, 7'b0000000, 0, K_ALU, 0, 4'b0000, 3'b011, 2'b10, 1, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[11] = mk(7'b0010111, 3'b000, 7'b0000000, 0, K_ALU, 0, 4'b0000, 3'b011, 2'b01, 1, 3'b000, 5'b00000, 2'b00, 2'b00);
      vecs[12] = mk(7'b1111111, 3'b000, 7'b0000000, 0, K_ILL, 0, 4'b0000, 3'b000, 2'b00, 0, 3'b000, 5'b00000, 2'b00, 2'b00);
      v_mul    = mk(7'b0110011, 3'b000, 7'b0000001, 0, K_MD,  0, 4'b0000, 3'b000, 2'b00, 0, 3'b000, 5'b00000, 2'b11, 2'b00);

      @(negedge clk);
      do_reset();
      // FETCH requests memory from the first cycle out of reset and waits for mem_ready.
      for (int i = 0; i < 2; i++) begin
         e = '0; e.mem_req = 1'b1;
         step("fetch_stall", e);
      end

      for (int i = 0; i < 13; i++) run(vecs[i], 1'b0);

      // M-op: main copy runs MULDIV, the ENABLE_M=0 copy traps and stays trapped.
      do_reset();
      run(v_mul, 1'b0);
      exp0 = '0; exp0.busy = 1'b1; exp0.illegal = 1'b1;
      chk0 = 1'b1;
      run(vecs[0], 1'b0);
      exp0 = '0;
      do_reset();
      chk0 = 1'b0;

      // Reset in the middle of a store wait and of a MULDIV occupancy.
      run(vecs[5], 1'b1);
      run(v_mul, 1'b1);
      run(vecs[1], 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
